// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM -> WB pipeline register with a one-entry skid buffer.
//
// The main register drives the WB_* outputs; the skid register catches the
// entry that arrives while the main register is stalled downstream. Because
// MEM_ready_out is decoded from the registered state only, there is no
// combinational path from WB_ready_in back to MEM_ready_out.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high (MEM_valid_in & MEM_ready_out = accept,
// WB_valid_out & WB_ready_in = fire). An asserted valid does not depend on
// ready.
//
// Ports:
//   clk, Reset (sync, active-high), Flush (sync discard of held entries)
//   MEM_valid_in / MEM_ready_out / MEM_PD_in / MEM_RD_in / MEM_RF_LE_in
//   WB_valid_out / WB_ready_in / WB_PD_out / WB_RD_out / WB_RF_LE_out
//   state_dbg        : current occupancy state (0 EMPTY, 1 ONE, 2 TWO)
//   WB_stall_cnt_out : 16-bit saturating stall counter, present only when
//                      the macro MEM_WB_SKID_STALL_CNT_EN is defined
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              MEM_valid_in,
    output logic              MEM_ready_out,
    input  logic [DATA_W-1:0] MEM_PD_in,
    input  logic [RD_W-1:0]   MEM_RD_in,
    input  logic              MEM_RF_LE_in,
    output logic              WB_valid_out,
    input  logic              WB_ready_in,
    output logic [DATA_W-1:0] WB_PD_out,
    output logic [RD_W-1:0]   WB_RD_out,
    output logic              WB_RF_LE_out,
    output logic [1:0]        state_dbg
`ifdef MEM_WB_SKID_STALL_CNT_EN
    ,
    output logic [15:0]       WB_stall_cnt_out
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] main_pd, skid_pd;
    logic [RD_W-1:0]   main_rd, skid_rd;
    logic              main_le, skid_le;
    logic              accept, fire;

    // Reset gates ready so nothing is accepted in a reset cycle.
    assign MEM_ready_out = (state != S_TWO) && !Reset;
    assign WB_valid_out  = (state == S_ONE) || (state == S_TWO);
    assign accept        = MEM_valid_in && MEM_ready_out;
    assign fire          = WB_valid_out && WB_ready_in;

    assign WB_PD_out     = main_pd;
    assign WB_RD_out     = main_rd;
    assign WB_RF_LE_out  = main_le && WB_valid_out;
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= S_EMPTY;
            main_pd <= '0;
            main_rd <= '0;
            main_le <= 1'b0;
            skid_pd <= '0;
            skid_rd <= '0;
            skid_le <= 1'b0;
        end else if (Flush) begin
            // Payload is left as-is; only the state marks it invalid.
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_pd <= MEM_PD_in;
                        main_rd <= MEM_RD_in;
                        main_le <= MEM_RF_LE_in;
                        state   <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && fire) begin
                        main_pd <= MEM_PD_in;
                        main_rd <= MEM_RD_in;
                        main_le <= MEM_RF_LE_in;
                    end else if (accept) begin
                        // Head is stalled: park the newcomer behind it.
                        skid_pd <= MEM_PD_in;
                        skid_rd <= MEM_RD_in;
                        skid_le <= MEM_RF_LE_in;
                        state   <= S_TWO;
                    end else if (fire) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (fire) begin
                        main_pd <= skid_pd;
                        main_rd <= skid_rd;
                        main_le <= skid_le;
                        state   <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

`ifdef MEM_WB_SKID_STALL_CNT_EN
    // Counts cycles where the head is offered but not taken; Flush does not
    // clear it so stall history survives pipeline flushes.
    always_ff @(posedge clk) begin
        if (Reset) begin
            WB_stall_cnt_out <= '0;
        end else if (WB_valid_out && !WB_ready_in && (WB_stall_cnt_out != 16'hFFFF)) begin
            WB_stall_cnt_out <= WB_stall_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

    logic        clk = 1'b0;
    logic        Reset, Flush;
    logic        MEM_valid_in, MEM_ready_out;
    logic [31:0] MEM_PD_in;
    logic [4:0]  MEM_RD_in;
    logic        MEM_RF_LE_in;
    logic        WB_valid_out, WB_ready_in;
    logic [31:0] WB_PD_out;
    logic [4:0]  WB_RD_out;
    logic        WB_RF_LE_out;
    logic [1:0]  state_dbg;
`ifdef MEM_WB_SKID_STALL_CNT_EN
    logic [15:0] WB_stall_cnt_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: {PD, RD, LE} of every entry the model says was accepted.
    logic [37:0] exp_q[$];
    int          m_cnt  = 0;
    logic        mon_en = 1'b0;
    logic        m_ready, m_acc, m_fire;

    mem_wb_skid #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .Reset(Reset), .Flush(Flush),
        .MEM_valid_in(MEM_valid_in), .MEM_ready_out(MEM_ready_out),
        .MEM_PD_in(MEM_PD_in), .MEM_RD_in(MEM_RD_in), .MEM_RF_LE_in(MEM_RF_LE_in),
        .WB_valid_out(WB_valid_out), .WB_ready_in(WB_ready_in),
        .WB_PD_out(WB_PD_out), .WB_RD_out(WB_RD_out), .WB_RF_LE_out(WB_RF_LE_out),
        .state_dbg(state_dbg)
`ifdef MEM_WB_SKID_STALL_CNT_EN
        , .WB_stall_cnt_out(WB_stall_cnt_out)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- occupancy model + scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            m_ready = (m_cnt < 2) && !Reset;
            m_acc   = MEM_valid_in && m_ready;
            m_fire  = (m_cnt > 0) && WB_ready_in;
            n_vec++;
            if (MEM_ready_out !== m_ready) begin
                n_err++;
                $display("FAIL mon_ready: got %b exp %b at %0t", MEM_ready_out, m_ready, $time);
            end
            n_vec++;
            if (WB_valid_out !== (m_cnt > 0)) begin
                n_err++;
                $display("FAIL mon_valid: got %b exp %b at %0t", WB_valid_out, (m_cnt > 0), $time);
            end
            if (m_cnt > 0) begin
                n_vec++;
                if ({WB_PD_out, WB_RD_out, WB_RF_LE_out} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL mon_head: got %h/%0d/%b exp %h/%0d/%b at %0t",
                             WB_PD_out, WB_RD_out, WB_RF_LE_out,
                             exp_q[0][37:6], exp_q[0][5:1], exp_q[0][0], $time);
                end
            end else begin
                n_vec++;
                if (WB_RF_LE_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL mon_le_gate: got %b exp 0 at %0t", WB_RF_LE_out, $time);
                end
            end
            if (Reset || Flush) begin
                exp_q.delete();
                m_cnt = 0;
            end else begin
                if (m_fire) void'(exp_q.pop_front());
                if (m_acc) exp_q.push_back({MEM_PD_in, MEM_RD_in, MEM_RF_LE_in});
                m_cnt = m_cnt + (m_acc ? 1 : 0) - (m_fire ? 1 : 0);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pd, input logic [4:0] rd, input logic le);
        MEM_valid_in = v;
        MEM_PD_in    = pd;
        MEM_RD_in    = rd;
        MEM_RF_LE_in = le;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        WB_ready_in = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, exp 0", exp_q.size());
        end
        WB_ready_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        Flush = 1'b0;
        WB_ready_in = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        cycle();
        mon_en = 1'b1;
        cycle();
        n_vec++;
        if ({WB_valid_out, WB_PD_out, WB_RD_out, WB_RF_LE_out, MEM_ready_out} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_outs: v=%b pd=%h rd=%0d le=%b rdy=%b exp all 0",
                     WB_valid_out, WB_PD_out, WB_RD_out, WB_RF_LE_out, MEM_ready_out);
        end
        Reset = 1'b0;
        #1;
        n_vec++;
        if (MEM_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b exp 1", MEM_ready_out);
        end
    endtask

    task automatic test_single();
        WB_ready_in = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_vec++;
        if ({WB_valid_out, WB_PD_out, WB_RD_out, WB_RF_LE_out} !== {1'b1, 32'hDEADBEEF, 5'd7, 1'b1}) begin
            n_err++;
            $display("FAIL single_out: v=%b pd=%h rd=%0d le=%b exp 1/deadbeef/7/1",
                     WB_valid_out, WB_PD_out, WB_RD_out, WB_RF_LE_out);
        end
        cycle();
        n_vec++;
        if ({WB_valid_out, WB_RF_LE_out} !== 2'b00) begin
            n_err++;
            $display("FAIL single_empty: v=%b le=%b exp 0/0", WB_valid_out, WB_RF_LE_out);
        end
        WB_ready_in = 1'b0;
    endtask

    task automatic test_stall_order();
        logic [31:0] exp_pd[3];
        exp_pd[0] = 32'h1;
        exp_pd[1] = 32'h2;
        exp_pd[2] = 32'h3;
        WB_ready_in = 1'b0;
        drive(1'b1, 32'h1, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 32'h2, 5'd2, 1'b0);
        cycle();
        drive(1'b1, 32'h3, 5'd3, 1'b1);
        cycle();
        n_vec++;
        if ({state_dbg, MEM_ready_out, WB_PD_out} !== {2'd2, 1'b0, 32'h1}) begin
            n_err++;
            $display("FAIL stall_two: st=%0d rdy=%b pd=%h exp 2/0/1", state_dbg, MEM_ready_out, WB_PD_out);
        end
        WB_ready_in = 1'b1;
        for (int i = 1; i < 3; i++) begin
            cycle();
            if (i == 2) drive(1'b0, 32'h0, 5'd0, 1'b0);
            n_vec++;
            if ({WB_valid_out, WB_PD_out} !== {1'b1, exp_pd[i]}) begin
                n_err++;
                $display("FAIL stall_order%0d: v=%b pd=%h exp 1/%h", i, WB_valid_out, WB_PD_out, exp_pd[i]);
            end
        end
        cycle();
        n_vec++;
        if (WB_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL stall_end: v=%b exp 0", WB_valid_out);
        end
        WB_ready_in = 1'b0;
    endtask

    task automatic test_stream();
        WB_ready_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, i, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            cycle();
            n_vec++;
            if ({WB_valid_out, WB_PD_out, MEM_ready_out} !== {1'b1, 32'(i), 1'b1}) begin
                n_err++;
                $display("FAIL stream%0d: v=%b pd=%h rdy=%b exp 1/%h/1", i, WB_valid_out, WB_PD_out, MEM_ready_out, i);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        WB_ready_in = 1'b0;
        drive(1'b1, 32'hA0, 5'd10, 1'b1);
        cycle();
        drive(1'b1, 32'hB0, 5'd11, 1'b1);
        cycle();
        Flush = 1'b1;
        drive(1'b1, 32'hD0, 5'd13, 1'b1);
        cycle();
        Flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_vec++;
        if ({WB_valid_out, WB_RF_LE_out, MEM_ready_out, state_dbg} !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL flush_two: v=%b le=%b rdy=%b st=%0d exp 0/0/1/0",
                     WB_valid_out, WB_RF_LE_out, MEM_ready_out, state_dbg);
        end
        drive(1'b1, 32'hE0, 5'd14, 1'b1);
        cycle();
        Flush = 1'b1;
        drive(1'b1, 32'hF0, 5'd15, 1'b1);
        cycle();
        Flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_vec++;
        if ({WB_valid_out, WB_RF_LE_out} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_one: v=%b le=%b exp 0/0", WB_valid_out, WB_RF_LE_out);
        end
        WB_ready_in = 1'b1;
        drive(1'b1, 32'h60, 5'd16, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        n_vec++;
        if ({WB_valid_out, WB_PD_out} !== {1'b1, 32'h60}) begin
            n_err++;
            $display("FAIL flush_after: v=%b pd=%h exp 1/60", WB_valid_out, WB_PD_out);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        WB_ready_in = 1'b0;
        drive(1'b1, 32'h11, 5'd21, 1'b1);
        cycle();
        drive(1'b1, 32'h22, 5'd22, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        repeat (5) cycle();
`ifdef MEM_WB_SKID_STALL_CNT_EN
        n_vec++;
        if (WB_stall_cnt_out !== 16'd6) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d exp 6", WB_stall_cnt_out);
        end
`endif
        Reset = 1'b1;
        drive(1'b1, 32'h33, 5'd23, 1'b1);
        cycle();
        n_vec++;
        if ({WB_valid_out, WB_PD_out, WB_RD_out, WB_RF_LE_out, MEM_ready_out} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_mid: v=%b pd=%h rd=%0d le=%b rdy=%b exp all 0",
                     WB_valid_out, WB_PD_out, WB_RD_out, WB_RF_LE_out, MEM_ready_out);
        end
`ifdef MEM_WB_SKID_STALL_CNT_EN
        n_vec++;
        if (WB_stall_cnt_out !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d exp 0", WB_stall_cnt_out);
        end
`endif
        Reset = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        cycle();
        n_vec++;
        if ({WB_valid_out, MEM_ready_out} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_mid_after: v=%b rdy=%b exp 0/1", WB_valid_out, MEM_ready_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            WB_ready_in = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();
    endtask

`ifdef MEM_WB_SKID_STALL_CNT_EN
    task automatic test_stall_sat();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        WB_ready_in = 1'b0;
        drive(1'b1, 32'h77, 5'd1, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        repeat (70000) cycle();
        n_vec++;
        if (WB_stall_cnt_out !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stall_sat: got %h exp ffff", WB_stall_cnt_out);
        end
        repeat (10) cycle();
        n_vec++;
        if (WB_stall_cnt_out !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stall_sat_hold: got %h exp ffff", WB_stall_cnt_out);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall_order();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef MEM_WB_SKID_STALL_CNT_EN
        test_stall_sat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 Parameter DATA_W, 32, width of the write-back data payload (PD).
REQ-002 Parameter RD_W, 5, width of the destination register index (RD).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1  reset; synchronous, active-high.
REQ-005 Port Flush  input  1  synchronous discard of all held entries.
REQ-006 Port MEM_valid_in  input  1  upstream entry present.
REQ-007 Port MEM_ready_out  output  1  block can accept an entry this cycle.
REQ-008 Port MEM_PD_in  input  DATA_W  write-back data.
REQ-009 Port MEM_RD_in  input  RD_W  destination register index.
REQ-010 Port MEM_RF_LE_in  input  1  register-file load enable.
REQ-011 Port WB_valid_out  output  1  head entry present.
REQ-012 Port WB_ready_in  input  1  downstream consumes the head entry.
REQ-013 Port WB_PD_out  output  DATA_W  head-entry data.
REQ-014 Port WB_RD_out  output  RD_W  head-entry index.
REQ-015 Port WB_RF_LE_out  output  1  head-entry load enable, gated by WB_valid_out.

Function
REQ-016 Accept when MEM_valid_in & MEM_ready_out; fire when WB_valid_out & WB_ready_in.
REQ-017 Storage: main register (drives WB_* outputs) plus one skid register; states EMPTY, ONE, TWO.
REQ-018 MEM_ready_out = 1 in EMPTY and ONE, 0 in TWO and while Reset is high; decoded from state only, no combinational path from WB_ready_in.
REQ-019 EMPTY: accept -> ONE, entry loaded into main; otherwise stays EMPTY.
REQ-020 ONE: accept & fire -> ONE, main <= new entry; accept & no fire -> TWO, skid <= new entry; fire & no accept -> EMPTY; otherwise hold.
REQ-021 TWO: fire -> ONE, main <= skid; no fire -> hold, all payload unchanged.
REQ-022 Latency: accepted entry appears on WB_* outputs exactly 1 cycle after acceptance when main is empty or firing.
REQ-023 Ordering: entries leave strictly in acceptance order; no entry duplicated or dropped except by Flush/Reset.
REQ-024 WB_valid_out = 1 in ONE and TWO; WB_RF_LE_out = stored RF_LE & WB_valid_out.
REQ-025 Payload registers hold value while not loaded; WB_PD_out/WB_RD_out need not be 0 when WB_valid_out = 0, except after reset.
REQ-026 Flush: next state EMPTY; any entry accepted in the same cycle is discarded; WB_valid_out and WB_RF_LE_out = 0 the following cycle.
REQ-027 Priority: Reset > Flush > accept/fire.
REQ-028 Widths: payload stored and output bit-exact, no extension or truncation.

Reset
REQ-029 Reset high at a rising edge: state EMPTY, main and skid payloads cleared to 0.
REQ-030 After reset: WB_valid_out=0, WB_PD_out=0, WB_RD_out=0, WB_RF_LE_out=0; MEM_ready_out=1 on the first cycle with Reset low.
REQ-031 Reset asserted mid-operation discards both held entries; no entry accepted in any cycle with Reset high.

Configuration
REQ-032 Macro MEM_WB_SKID_STALL_CNT_EN defined: adds output WB_stall_cnt_out (16 bits) counting cycles with WB_valid_out & !WB_ready_in, saturating at 16'hFFFF, cleared by Reset (not by Flush).
REQ-033 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-034 Reset, then one entry PD=32'hDEADBEEF RD=5'd7 RF_LE=1 with WB_ready_in=1 -> WB outputs show it 1 cycle later with WB_valid_out=1, then WB_valid_out=0 on the next cycle.
REQ-035 WB_ready_in=0; push A=32'h1, B=32'h2 on consecutive cycles -> state TWO, MEM_ready_out=0, C=32'h3 held upstream; raise WB_ready_in -> outputs A, B, C in order, one per cycle.
REQ-036 Continuous MEM_valid_in=1 and WB_ready_in=1 for 100 cycles, PD = cycle index -> 100 entries out in order, MEM_ready_out constantly 1, throughput 1 per cycle.
REQ-037 State TWO, Flush=1 with MEM_valid_in=1 -> next cycle WB_valid_out=0, WB_RF_LE_out=0, MEM_ready_out=1; flushed and concurrent entries never appear.
REQ-038 Reset asserted while in TWO with stalls accumulated -> all outputs 0 next cycle; with MEM_WB_SKID_STALL_CNT_EN, WB_stall_cnt_out=0.
REQ-039 With MEM_WB_SKID_STALL_CNT_EN, hold one entry stalled 70000 cycles -> WB_stall_cnt_out reaches 16'hFFFF and stays there.
